// File: rtl/ps2_command_buffer.sv
// PS/2 scancode line editor: make codes become ASCII in a DEPTH-char line; Enter commits it to a valid/ready holding register.
// One-cycle latency per byte; a busy holding register or a full line drops the byte. Optional shift handling: CMD_BUF_SHIFT_EN.
module ps2_command_buffer #(
  parameter int DEPTH = 4,
  parameter int LEN_W = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [7:0]           key_data,
  input  logic                 key_valid,
  output logic [DEPTH*8-1:0]   cmd_data,
  output logic [LEN_W-1:0]     cmd_len,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic [LEN_W-1:0]     line_len,
  output logic                 full,
  output logic                 drop
);

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

  state_t               state_q, state_d;
  logic [DEPTH*8-1:0]   line_q, line_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [DEPTH*8-1:0]   cmd_data_q, cmd_data_d;
  logic [LEN_W-1:0]     cmd_len_q, cmd_len_d;
  logic                 cmd_valid_q, cmd_valid_d;
  logic                 drop_q, drop_d;
  logic [8:0]           mapped;
  logic [7:0]           ch;
`ifdef CMD_BUF_SHIFT_EN
  logic                 shift_q, shift_d;
`endif

  // Bit 8 flags a letter; an ASCII value of 0 means the code is unmapped.
  function automatic logic [8:0] map_code(input logic [7:0] code);
    case (code)
      8'h1C: map_code = {1'b1, 8'h41}; 8'h32: map_code = {1'b1, 8'h42};
      8'h21: map_code = {1'b1, 8'h43}; 8'h23: map_code = {1'b1, 8'h44};
      8'h24: map_code = {1'b1, 8'h45}; 8'h2B: map_code = {1'b1, 8'h46};
      8'h34: map_code = {1'b1, 8'h47}; 8'h33: map_code = {1'b1, 8'h48};
      8'h43: map_code = {1'b1, 8'h49}; 8'h3B: map_code = {1'b1, 8'h4A};
      8'h42: map_code = {1'b1, 8'h4B}; 8'h4B: map_code = {1'b1, 8'h4C};
      8'h3A: map_code = {1'b1, 8'h4D}; 8'h31: map_code = {1'b1, 8'h4E};
      8'h44: map_code = {1'b1, 8'h4F}; 8'h4D: map_code = {1'b1, 8'h50};
      8'h15: map_code = {1'b1, 8'h51}; 8'h2D: map_code = {1'b1, 8'h52};
      8'h1B: map_code = {1'b1, 8'h53}; 8'h2C: map_code = {1'b1, 8'h54};
      8'h3C: map_code = {1'b1, 8'h55}; 8'h2A: map_code = {1'b1, 8'h56};
      8'h1D: map_code = {1'b1, 8'h57}; 8'h22: map_code = {1'b1, 8'h58};
      8'h35: map_code = {1'b1, 8'h59}; 8'h1A: map_code = {1'b1, 8'h5A};
      8'h45: map_code = {1'b0, 8'h30}; 8'h16: map_code = {1'b0, 8'h31};
      8'h1E: map_code = {1'b0, 8'h32}; 8'h26: map_code = {1'b0, 8'h33};
      8'h25: map_code = {1'b0, 8'h34}; 8'h2E: map_code = {1'b0, 8'h35};
      8'h36: map_code = {1'b0, 8'h36}; 8'h3D: map_code = {1'b0, 8'h37};
      8'h3E: map_code = {1'b0, 8'h38}; 8'h46: map_code = {1'b0, 8'h39};
      8'h29: map_code = {1'b0, 8'h20};
      default: map_code = 9'h000;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    line_d      = line_q;
    len_d       = len_q;
    cmd_data_d  = cmd_data_q;
    cmd_len_d   = cmd_len_q;
    cmd_valid_d = cmd_valid_q;
    drop_d      = 1'b0;
    mapped      = map_code(key_data);
    ch          = mapped[7:0];
`ifdef CMD_BUF_SHIFT_EN
    shift_d     = shift_q;
    if (mapped[8] && !shift_q) ch = mapped[7:0] | 8'h20;
`endif

    if (cmd_valid_q && cmd_ready) cmd_valid_d = 1'b0;

    if (key_valid) begin
      case (state_q)
        IDLE: begin
          if (key_data == 8'hF0) begin
            state_d = BRK;
          end else if (key_data == 8'hE0) begin
            state_d = EXT;
          end else if (key_data == 8'h66) begin
            if (len_q != '0) begin
              line_d = line_q >> 8;
              len_d  = len_q - LEN_W'(1);
            end
          end else if (key_data == 8'h5A) begin
            // A handshake in this same cycle frees the holding register.
            if (len_q != '0) begin
              if (!cmd_valid_q || cmd_ready) begin
                cmd_data_d  = line_q;
                cmd_len_d   = len_q;
                cmd_valid_d = 1'b1;
                line_d      = '0;
                len_d       = '0;
              end else begin
                drop_d = 1'b1;
              end
            end
`ifdef CMD_BUF_SHIFT_EN
          end else if (key_data == 8'h12 || key_data == 8'h59) begin
            shift_d = 1'b1;
`endif
          end else if (ch != 8'h00) begin
            if (len_q == DEPTH_L) begin
              drop_d = 1'b1;
            end else begin
              line_d      = line_q << 8;
              line_d[7:0] = ch;
              len_d       = len_q + LEN_W'(1);
            end
          end
        end
        BRK: begin
`ifdef CMD_BUF_SHIFT_EN
          if (key_data == 8'h12 || key_data == 8'h59) shift_d = 1'b0;
`endif
          state_d = IDLE;
        end
        EXT:     state_d = (key_data == 8'hF0) ? EXT_BRK : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      line_q      <= '0;
      len_q       <= '0;
      cmd_data_q  <= '0;
      cmd_len_q   <= '0;
      cmd_valid_q <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      line_q      <= line_d;
      len_q       <= len_d;
      cmd_data_q  <= cmd_data_d;
      cmd_len_q   <= cmd_len_d;
      cmd_valid_q <= cmd_valid_d;
      drop_q      <= drop_d;
    end
  end

`ifdef CMD_BUF_SHIFT_EN
  always_ff @(posedge clock) begin
    if (reset) shift_q <= 1'b0;
    else       shift_q <= shift_d;
  end
`endif

  assign cmd_data  = cmd_data_q;
  assign cmd_len   = cmd_len_q;
  assign cmd_valid = cmd_valid_q;
  assign line_len  = len_q;
  assign full      = (len_q == DEPTH_L);
  assign drop      = drop_q;

endmodule

// File: tb/tb_ps2_command_buffer.sv
// Bench for ps2_command_buffer: directed scancode vectors, expected commands queued, handshake monitor compares.
module tb_ps2_command_buffer;

  localparam int DEPTH = 4;
  localparam int LEN_W = 3;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic [7:0]           key_data = 8'h00;
  logic                 key_valid = 1'b0;
  logic [DEPTH*8-1:0]   cmd_data;
  logic [LEN_W-1:0]     cmd_len;
  logic                 cmd_valid;
  logic                 cmd_ready = 1'b0;
  logic [LEN_W-1:0]     line_len;
  logic                 full;
  logic                 drop;

  int checks = 0;
  int failures = 0;
  int drop_cnt = 0;
  int drop_base;
  int pops = 0;
  logic drop_prev = 1'b0;

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  len;
  } exp_t;
  exp_t exp_q[$];

  ps2_command_buffer #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clock(clock), .reset(reset), .key_data(key_data), .key_valid(key_valid),
    .cmd_data(cmd_data), .cmd_len(cmd_len), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .line_len(line_len), .full(full), .drop(drop)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare every accepted command against the queue, count drop pulses.
  always @(negedge clock) begin
    if (!reset && cmd_valid && cmd_ready) begin
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_cmd: got data 0x%0h len %0d, none queued", cmd_data, cmd_len);
      end else begin
        e = exp_q.pop_front();
        pops++;
        if (cmd_data !== e.data || cmd_len !== e.len) begin
          failures++;
          $display("FAIL cmd_pop: got data 0x%0h len %0d want data 0x%0h len %0d",
                   cmd_data, cmd_len, e.data, e.len);
        end
      end
    end
    if (!reset && drop) begin
      drop_cnt++;
      checks++;
      if (drop_prev) begin
        failures++;
        $display("FAIL drop_width: got 2+ cycles want 1");
      end
    end
    drop_prev <= drop;
  end

  task automatic send(input logic [7:0] b);
    key_data  = b;
    key_valid = 1'b1;
    @(posedge clock); #1;
    key_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic accept();
    cmd_ready = 1'b1;
    @(posedge clock); #1;
    cmd_ready = 1'b0;
  endtask

  task automatic expect_cmd(input logic [31:0] d, input logic [2:0] l);
    exp_t e;
    e.data = d;
    e.len  = l;
    exp_q.push_back(e);
  endtask

  initial begin
    int total_push;
    total_push = 0;
    idle(3);
    reset = 1'b0;
    chk("rst_line_len", 64'(line_len), 0);
    chk("rst_full", 64'(full), 0);
    chk("rst_cmd_valid", 64'(cmd_valid), 0);
    chk("rst_cmd_data", 64'(cmd_data), 0);
    chk("rst_cmd_len", 64'(cmd_len), 0);
    chk("rst_drop", 64'(drop), 0);

    // Typing "TE" with releases, commit, held then accepted.
    send(8'h2C); send(8'hF0); send(8'h2C); send(8'h24); send(8'hF0); send(8'h24);
    chk("te_line_len", 64'(line_len), 2);
    expect_cmd(32'h0000_5445, 3'd2); total_push++;
    send(8'h5A);
    chk("te_cmd_valid", 64'(cmd_valid), 1);
    chk("te_cmd_data", 64'(cmd_data), 64'h5445);
    chk("te_cmd_len", 64'(cmd_len), 2);
    chk("te_line_cleared", 64'(line_len), 0);
    idle(3);
    chk("te_cmd_held", 64'(cmd_valid), 1);
    accept();
    chk("te_cmd_fall", 64'(cmd_valid), 0);

    // Overflow: fifth letter dropped.
    drop_base = drop_cnt;
    send(8'h1C); send(8'h32); send(8'h21); send(8'h23);
    chk("ovf_full", 64'(full), 1);
    chk("ovf_len4", 64'(line_len), 4);
    chk("ovf_no_drop_yet", 64'(drop), 0);
    send(8'h24);
    chk("ovf_drop", 64'(drop), 1);
    chk("ovf_len_kept", 64'(line_len), 4);
    idle(1);
    chk("ovf_drop_cleared", 64'(drop), 0);
    chk("ovf_drop_count", 64'(drop_cnt - drop_base), 1);
    expect_cmd(32'h4142_4344, 3'd4); total_push++;
    send(8'h5A);
    accept();

    // Backspace and underflow guard.
    send(8'h16); send(8'h1E); send(8'h66);
    chk("bs_len1", 64'(line_len), 1);
    chk("bs_not_full", 64'(full), 0);
    drop_base = drop_cnt;
    send(8'h66); send(8'h66);
    chk("bs_len0", 64'(line_len), 0);
    chk("bs_no_drop", 64'(drop_cnt - drop_base), 0);
    send(8'h16);
    expect_cmd(32'h0000_0031, 3'd1); total_push++;
    send(8'h5A);
    accept();

    // Extended and break bytes never reach the line; empty Enter ignored.
    drop_base = drop_cnt;
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75); send(8'hF0); send(8'h1C);
    send(8'h5A);
    chk("ext_len0", 64'(line_len), 0);
    chk("ext_no_cmd", 64'(cmd_valid), 0);
    chk("ext_no_drop", 64'(drop_cnt - drop_base), 0);

    // Reset after a break prefix: next byte is a make code.
    send(8'hF0);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    send(8'h1C);
    chk("rstmid_len1", 64'(line_len), 1);
    expect_cmd(32'h0000_0041, 3'd1); total_push++;
    send(8'h5A);
    accept();

    // Busy holding register: Enter dropped, then Enter with simultaneous accept.
    expect_cmd(32'h0000_0042, 3'd1); total_push++;
    send(8'h32); send(8'h5A);
    send(8'h1C);
    drop_base = drop_cnt;
    send(8'h5A);
    chk("busy_drop", 64'(drop), 1);
    chk("busy_line_kept", 64'(line_len), 1);
    chk("busy_cmd_kept", 64'(cmd_data), 64'h42);
    chk("busy_cmd_valid", 64'(cmd_valid), 1);
    idle(1);
    chk("busy_drop_count", 64'(drop_cnt - drop_base), 1);
    expect_cmd(32'h0000_0041, 3'd1); total_push++;
    cmd_ready = 1'b1;
    send(8'h5A);
    cmd_ready = 1'b0;
    chk("swap_cmd_valid", 64'(cmd_valid), 1);
    chk("swap_cmd_data", 64'(cmd_data), 64'h41);
    chk("swap_line_len", 64'(line_len), 0);
    accept();
    chk("swap_cmd_fall", 64'(cmd_valid), 0);

    // Shift handling.
`ifdef CMD_BUF_SHIFT_EN
    send(8'h1C);
    send(8'h12); send(8'h1C);
    send(8'hF0); send(8'h12); send(8'h1C);
    chk("shift_len3", 64'(line_len), 3);
    expect_cmd(32'h0061_4161, 3'd3); total_push++;
`else
    send(8'h12); send(8'h1C); send(8'h59);
    chk("noshift_len1", 64'(line_len), 1);
    expect_cmd(32'h0000_0041, 3'd1); total_push++;
`endif
    send(8'h5A);
    accept();

    idle(2);
    chk("all_cmds_seen", 64'(pops), 64'(total_push));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
